dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: the processor core (port C, load/store) and an external master (port X, program loader or debug).
- Sits between the core's ALU_Result/Reg_out_2/Mem_write path and Data_memory.
- Grant and read data are combinational in the request cycle, so the single-cycle core keeps its timing. A registered FSM, a starvation counter and a burst counter provide fairness and locked bursts.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive denied X-cycles before X is forced priority (1..255)
MAX_BURST, 4, maximum consecutive locked X grants (1..255)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-low reset
c_req  in  1  core memory access request
c_we  in  1  core write enable
c_addr  in  ADDR_W  core address
c_wdata  in  DATA_W  core write data
c_gnt  out  1  core granted this cycle
c_rdata  out  DATA_W  core read data
c_stall  out  1  core must hold PC/writeback (c_req & ~c_gnt)
x_req  in  1  external request
x_we  in  1  external write enable
x_lock  in  1  external requests burst ownership
x_addr  in  ADDR_W  external address
x_wdata  in  DATA_W  external write data
x_gnt  out  1  external granted this cycle
x_rdata  out  DATA_W  external read data
mem_we  out  1  to Data_memory WE
mem_addr  out  ADDR_W  to Data_memory A
mem_wd  out  DATA_W  to Data_memory WD
mem_rd  in  DATA_W  from Data_memory RD (combinational read)

Behaviour:
- Registered state:
  - owner: OWN_C or OWN_X; the owner of the previous granted cycle.
  - starve_cnt: 8 bits.
  - burst_cnt: 8 bits.
- Reset (rst=0 at clk edge): owner=OWN_C, starve_cnt=0, burst_cnt=0.
- While rst=0: c_gnt=x_gnt=0, mem_we=0, c_stall=0.
- Grant priority, evaluated combinationally each cycle, first match wins:
  1. owner==OWN_X & x_lock & x_req & burst_cnt<MAX_BURST -> X.
  2. x_req & (starve_cnt==STARVE_LIMIT | ~c_req) -> X.
  3. c_req -> C.
  4. Otherwise no grant.
- Exactly one of c_gnt/x_gnt is high, or neither; never both.
- Memory mux:
  - Winner's addr/wdata drive mem_addr/mem_wd.
  - mem_we = winner's we & its gnt.
  - With no grant: mem_addr=0, mem_wd=0, mem_we=0.
- Read data: c_rdata = x_rdata = mem_rd, unconditionally. Data is valid only in that port's grant cycle with we=0; zero latency.
- Sequential updates:
  - owner <= winner when a grant occurs; unchanged otherwise.
  - starve_cnt <= 0 on x_gnt. It increments when x_req & ~x_gnt, saturating at STARVE_LIMIT. It holds when x_req=0.
  - burst_cnt <= burst_cnt+1 on x_gnt & x_lock. It resets to 0 on any cycle without (x_gnt & x_lock).
  - When burst_cnt reaches MAX_BURST, rule 1 no longer fires. X then competes via rule 2 only, and burst_cnt clears on the next non-locked or lost cycle.
- Simultaneous events:
  - c_req & x_req with starve_cnt<LIMIT and no active lock -> C wins.
  - Lock rising mid-stream takes effect only after X has won one cycle by rule 2.
- Reset mid-burst aborts the burst; no write issues in the reset cycle.
- c_stall = c_req & ~c_gnt. While stalled, the core must hold its PC and register-file write; the core wrapper gates WE with ~c_stall.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- When defined:
  - Adds outputs perf_c_stall [31:0] and perf_x_gnt [31:0].
  - perf_c_stall counts cycles with c_stall=1; perf_x_gnt counts cycles with x_gnt=1.
  - Both wrap at 2^32 and reset to 0 on rst=0.
- When undefined: ports absent, no counter logic.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - OWN_C/OWN_X owner encodings.
  - Default STARVE_LIMIT/MAX_BURST localparams.
  - The counter width constant (8).
- One sub-module: arb_sat_counter, a saturating/clearable counter instantiated for starve_cnt and burst_cnt.
- The grant mux stays inline.

Test Plan (STARVE_LIMIT=4, MAX_BURST=4):
- Reset: hold rst=0 with c_req=x_req=1 and both we=1 -> c_gnt=x_gnt=0, mem_we=0. After release -> c_gnt=1 first cycle.
- Core only: c_req=1, c_we=1, c_addr=0x10, c_wdata=0xDEADBEEF -> mem_we=1, mem_addr=0x10, c_stall=0. Next cycle read at 0x10 -> c_rdata=0xDEADBEEF same cycle.
- Contention/starvation: c_req=x_req=1 continuously -> c_gnt cycles 1-4, x_gnt cycle 5 (c_stall=1), then c_gnt cycles 6-9, x_gnt cycle 10.
- Locked burst:
  - Setup: c_req=0 for one cycle, x_req=x_lock=1 so X wins (burst_cnt=1).
  - Stimulus: then c_req=1 -> x_gnt holds 3 more cycles (burst_cnt 1..4), then c_gnt=1.
- Reset mid-burst: assert rst=0 during burst cycle 2 -> no mem_we that cycle. After release owner=C, burst_cnt=0, c_gnt wins contention.
- Perf (macro defined): repeat the contention scenario for 10 cycles -> perf_x_gnt=2, perf_c_stall=2.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared owner encoding, default fairness limits and the
// counter width used by the data-memory arbiter.
package dmem_arb_pkg;

  // Which port owned the most recent granted cycle
  typedef enum logic {
    OWN_C = 1'b0,
    OWN_X = 1'b1
  } owner_t;

  localparam int CNT_W             = 8;
  localparam int DEF_STARVE_LIMIT  = 4;
  localparam int DEF_MAX_BURST     = 4;

endpackage

// File: rtl/arb_sat_counter.sv
// arb_sat_counter: clearable up-counter that stops at a programmable limit.
// Used for both the starvation and the locked-burst counters.
module arb_sat_counter
#(
  parameter int W = 8
)
(
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Clear has priority over increment; increment holds once limit is reached
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count < limit)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the core (C)
// and an external master (X). Grant, mux and read data are combinational
// so the single-cycle core keeps its timing; owner, starvation and burst
// state are registered.
// Optional build macro DMEM_ARB_PERF_EN adds the perf_c_stall / perf_x_gnt
// cycle counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int MAX_BURST    = DEF_MAX_BURST
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_stall,
  input  logic              x_req,
  input  logic              x_we,
  input  logic              x_lock,
  input  logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] x_wdata,
  output logic              x_gnt,
  output logic [DATA_W-1:0] x_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_c_stall,
  output logic [31:0]       perf_x_gnt
`endif
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] BURST_LIM  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  owner_t           owner;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] burst_cnt;
  logic             grant_c;
  logic             grant_x;
  logic             burst_step;

  // Priority grant: locked burst continuation, then starved/uncontested X, then C
  always_comb begin
    grant_c = 1'b0;
    grant_x = 1'b0;
    if (rst) begin
      if ((owner == OWN_X) && x_lock && x_req && (burst_cnt < BURST_LIM)) begin
        grant_x = 1'b1;
      end else if (x_req && ((starve_cnt == STARVE_LIM) || !c_req)) begin
        grant_x = 1'b1;
      end else if (c_req) begin
        grant_c = 1'b1;
      end
    end
  end

  // Steer the winner onto the memory port; idle port drives zeros
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (grant_x) begin
      mem_we   = x_we;
      mem_addr = x_addr;
      mem_wd   = x_wdata;
    end else if (grant_c) begin
      mem_we   = c_we;
      mem_addr = c_addr;
      mem_wd   = c_wdata;
    end
  end

  assign c_gnt      = grant_c;
  assign x_gnt      = grant_x;
  assign c_stall    = rst & c_req & ~grant_c;
  assign c_rdata    = mem_rd;
  assign x_rdata    = mem_rd;
  assign burst_step = grant_x & x_lock;

  // Remember who won the last granted cycle; idle cycles keep the owner
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner <= OWN_C;
    end else if (grant_x) begin
      owner <= OWN_X;
    end else if (grant_c) begin
      owner <= OWN_C;
    end
  end

  arb_sat_counter #(.W(CNT_W)) u_starve_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (grant_x),
    .inc   (x_req),
    .limit (STARVE_LIM),
    .count (starve_cnt)
  );

  arb_sat_counter #(.W(CNT_W)) u_burst_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (~burst_step),
    .inc   (burst_step),
    .limit (CNT_MAX),
    .count (burst_cnt)
  );

`ifdef DMEM_ARB_PERF_EN
  // Free-running wrap-around counts of core stall cycles and X grants
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_c_stall <= '0;
      perf_x_gnt   <= '0;
    end else begin
      if (c_stall) perf_c_stall <= perf_c_stall + 32'd1;
      if (grant_x) perf_x_gnt   <= perf_x_gnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a
// rule-level reference model and a reference copy of data memory.
module tb_dmem_arbiter;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int SLIMIT = 4;
  localparam int MBURST = 4;

  logic          clk;
  logic          rst;
  logic          c_req, c_we, x_req, x_we, x_lock;
  logic [AW-1:0] c_addr, x_addr;
  logic [DW-1:0] c_wdata, x_wdata;
  logic          c_gnt, x_gnt, c_stall, mem_we;
  logic [DW-1:0] c_rdata, x_rdata, mem_wd, mem_rd;
  logic [AW-1:0] mem_addr;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0]   perf_c_stall, perf_x_gnt;
`endif

  logic [DW-1:0] env_mem [0:255];
  logic [DW-1:0] ref_mem [0:255];

  int checks   = 0;
  int failures = 0;

  int m_owner_x;
  int m_starve;
  int m_burst;
  int m_perf_stall;
  int m_perf_xgnt;

  logic          last_c_gnt;
  logic          last_x_gnt;
  logic          last_mem_we;
  logic [DW-1:0] last_c_rdata;

  dmem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SLIMIT), .MAX_BURST(MBURST)
  ) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rdata(c_rdata), .c_stall(c_stall),
    .x_req(x_req), .x_we(x_we), .x_lock(x_lock), .x_addr(x_addr),
    .x_wdata(x_wdata), .x_gnt(x_gnt), .x_rdata(x_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
`ifdef DMEM_ARB_PERF_EN
    , .perf_c_stall(perf_c_stall), .perf_x_gnt(perf_x_gnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Environment data memory: combinational read, write on rising edge
  assign mem_rd = env_mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (mem_we) env_mem[mem_addr[7:0]] <= mem_wd;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive inputs, check combinational outputs, advance the model
  task automatic applyStimulus(input logic r, input logic cr, input logic cw,
                               input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                               input logic xr, input logic xw, input logic xl,
                               input logic [AW-1:0] xa, input logic [DW-1:0] xd);
    int            win;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic          e_stall;
    @(negedge clk);
    rst = r; c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    x_req = xr; x_we = xw; x_lock = xl; x_addr = xa; x_wdata = xd;
    #1;
    // 0 = nobody, 1 = core, 2 = external
    if (!r) win = 0;
    else if (m_owner_x == 1 && xl && xr && m_burst < MBURST) win = 2;
    else if (xr && (m_starve == SLIMIT || !cr)) win = 2;
    else if (cr) win = 1;
    else win = 0;
    e_we = 1'b0; e_addr = '0; e_wd = '0;
    if (win == 2) begin e_we = xw; e_addr = xa; e_wd = xd; end
    if (win == 1) begin e_we = cw; e_addr = ca; e_wd = cd; end
    e_stall = r && cr && (win != 1);
    checkOutput("c_gnt",   {63'd0, c_gnt},   {63'd0, win == 1});
    checkOutput("x_gnt",   {63'd0, x_gnt},   {63'd0, win == 2});
    checkOutput("c_stall", {63'd0, c_stall}, {63'd0, e_stall});
    checkOutput("mem_we",  {63'd0, mem_we},  {63'd0, e_we});
    checkOutput("mem_addr", {32'd0, mem_addr}, {32'd0, e_addr});
    checkOutput("mem_wd",  {32'd0, mem_wd},  {32'd0, e_wd});
    checkOutput("c_rdata", {32'd0, c_rdata}, {32'd0, ref_mem[e_addr[7:0]]});
    checkOutput("x_rdata", {32'd0, x_rdata}, {32'd0, ref_mem[e_addr[7:0]]});
    last_c_gnt = c_gnt; last_x_gnt = x_gnt; last_mem_we = mem_we;
    last_c_rdata = c_rdata;
    if (!r) begin
      m_owner_x = 0; m_starve = 0; m_burst = 0;
      m_perf_stall = 0; m_perf_xgnt = 0;
    end else begin
      if (e_we) ref_mem[e_addr[7:0]] = e_wd;
      if (win == 2) m_owner_x = 1;
      else if (win == 1) m_owner_x = 0;
      if (win == 2) m_starve = 0;
      else if (xr) m_starve = (m_starve + 1 > SLIMIT) ? SLIMIT : m_starve + 1;
      if (win == 2 && xl) m_burst = (m_burst < 255) ? m_burst + 1 : 255;
      else m_burst = 0;
      if (e_stall) m_perf_stall = (m_perf_stall + 1) & 32'hFFFF_FFFF;
      if (win == 2) m_perf_xgnt = (m_perf_xgnt + 1) & 32'hFFFF_FFFF;
    end
  endtask

  task automatic resetCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = '0;
      ref_mem[i] = '0;
    end
    m_owner_x = 0; m_starve = 0; m_burst = 0;
    m_perf_stall = 0; m_perf_xgnt = 0;
    rst = 1'b0; c_req = 1'b0; c_we = 1'b0; x_req = 1'b0; x_we = 1'b0;
    x_lock = 1'b0; c_addr = '0; x_addr = '0; c_wdata = '0; x_wdata = '0;

    // Reset held with both ports requesting writes: nothing granted
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h4, 32'h1111, 1'b1, 1'b1, 1'b0, 32'h8, 32'h2222);
      checkOutput("rst_no_we", {63'd0, last_mem_we}, 64'd0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h4, '0, 1'b1, 1'b0, 1'b0, 32'h8, '0);
    checkOutput("rst_release_c", {63'd0, last_c_gnt}, 64'd1);

    // Core write then same-cycle read back
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h10, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    checkOutput("core_read", {32'd0, last_c_rdata}, {32'd0, 32'hDEADBEEF});

    // Continuous contention: X gets through on cycles 5 and 10
    resetCycle();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h20, '0, 1'b1, 1'b0, 1'b0, 32'h30, '0);
      checkOutput("contend_x", {63'd0, last_x_gnt}, {63'd0, (i == 4 || i == 9)});
    end
`ifdef DMEM_ARB_PERF_EN
    @(negedge clk);
    checkOutput("perf_x_gnt",   {32'd0, perf_x_gnt},   64'd2);
    checkOutput("perf_c_stall", {32'd0, perf_c_stall}, 64'd2);
`endif

    // Locked burst: X keeps the port MAX_BURST cycles, then C
    resetCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 32'h40, 32'hA0);
    checkOutput("burst_setup", {63'd0, last_x_gnt}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h50, '0, 1'b1, 1'b1, 1'b1,
                    32'h41 + i, 32'hA1 + i);
      checkOutput("burst_x", {63'd0, last_x_gnt}, {63'd0, i < 3});
    end

    // Reset during the second burst cycle aborts it with no write
    resetCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 32'h60, 32'hB0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 32'h61, 32'hB1);
    checkOutput("midburst_rst_we", {63'd0, last_mem_we}, 64'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h62, '0, 1'b1, 1'b1, 1'b1, 32'h61, 32'hB1);
    checkOutput("after_rst_c", {63'd0, last_c_gnt}, 64'd1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(31) != 0), 1'($urandom), 1'($urandom),
                    32'($urandom_range(63)), $urandom,
                    1'($urandom), 1'($urandom),
                    ($urandom_range(3) != 0),
                    32'($urandom_range(63)), $urandom);
    end
`ifdef DMEM_ARB_PERF_EN
    @(negedge clk);
    checkOutput("perf_x_gnt_rand",   {32'd0, perf_x_gnt},   64'(m_perf_xgnt));
    checkOutput("perf_c_stall_rand", {32'd0, perf_c_stall}, 64'(m_perf_stall));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
